// File: rtl/if_id_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : if_id_stage_pkg
// Description : Shared widths, reset/bubble values and opcodes for IF/ID.
// Revision    : 1.0  initial release
// ============================================================================
package if_id_stage_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [5:0]        opcode_t;

    localparam word_t   c_nop_instr = 32'h0000_0000;
    localparam word_t   c_reset_pc  = 32'h0000_0000;

    localparam opcode_t c_op_j   = 6'h02;
    localparam opcode_t c_op_beq = 6'h04;
    localparam opcode_t c_op_bne = 6'h05;

endpackage
`default_nettype wire

// File: rtl/if_id_reg.sv
`default_nettype none
// ============================================================================
// Module      : if_id_reg
// Description : IF/ID pipeline register with hold, flush-to-bubble and valid.
// Revision    : 1.0  initial release
// ============================================================================
module if_id_reg
    import if_id_stage_pkg::*;
#(
    parameter word_t NOP_INSTR = c_nop_instr
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  i_hold,
    input  logic  i_flush,
    input  word_t i_instr,
    input  word_t i_pcPlus4,
    output word_t o_instr,
    output word_t o_pcPlus4,
    output logic  o_valid
);

    word_t r_instr;
    word_t r_pcPlus4;
    logic  r_valid;

    // Hold wins over flush so a stalled redirect is not lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_instr   <= NOP_INSTR;
            r_pcPlus4 <= '0;
            r_valid   <= 1'b0;
        end else if (!i_hold) begin
            if (i_flush) begin
                r_instr   <= NOP_INSTR;
                r_pcPlus4 <= '0;
                r_valid   <= 1'b0;
            end else begin
                r_instr   <= i_instr;
                r_pcPlus4 <= i_pcPlus4;
                r_valid   <= 1'b1;
            end
        end
    end

    assign o_instr   = r_instr;
    assign o_pcPlus4 = r_pcPlus4;
    assign o_valid   = r_valid;

endmodule
`default_nettype wire

// File: rtl/if_id_stage.sv
`default_nettype none
// ============================================================================
// Module      : if_id_stage
// Description : PC register, next-PC selection and IF/ID register instance.
// Revision    : 1.0  initial release
// ============================================================================
module if_id_stage
    import if_id_stage_pkg::*;
#(
    parameter word_t RESET_PC  = c_reset_pc,
    parameter word_t NOP_INSTR = c_nop_instr
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              if_equal,
    input  logic              id_beq,
    input  logic              id_bne,
    input  logic              id_jump,
    input  logic [WORD_W-1:0] id_imm,
    input  logic [WORD_W-1:0] if_instr,
    output logic [WORD_W-1:0] pc_out,
    output logic [WORD_W-1:0] id_instr,
    output logic [WORD_W-1:0] id_pc_plus4,
    output logic              id_valid,
    output logic              redirect
);

    word_t r_pc;
    word_t w_pcNext;
    word_t w_pcPlus4;
    word_t w_branchTarget;
    word_t w_jumpTarget;
    logic  w_taken;
    logic  w_jumpTaken;
    logic  w_redirect;

    assign w_pcPlus4      = r_pc + 32'd4;
    assign w_branchTarget = id_pc_plus4 + (id_imm << 2);
    assign w_jumpTarget   = {id_pc_plus4[31:28], id_instr[25:0], 2'b00};

    // Control bits from a bubble are meaningless, so gate them with valid.
    assign w_taken     = id_valid & ((id_beq & if_equal) | (id_bne & ~if_equal));
    assign w_jumpTaken = id_valid & id_jump;
    assign w_redirect  = ~stall & (w_taken | w_jumpTaken);

    always_comb begin
        w_pcNext = w_pcPlus4;
        if (stall) begin
            w_pcNext = r_pc;
        end else if (w_jumpTaken) begin
            w_pcNext = w_jumpTarget;
        end else if (w_taken) begin
            w_pcNext = w_branchTarget;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= w_pcNext;
        end
    end

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_ifIdReg (
        .clk       (clk),
        .rst       (reset),
        .i_hold    (stall),
        .i_flush   (w_redirect),
        .i_instr   (if_instr),
        .i_pcPlus4 (w_pcPlus4),
        .o_instr   (id_instr),
        .o_pcPlus4 (id_pc_plus4),
        .o_valid   (id_valid)
    );

    assign pc_out   = r_pc;
    assign redirect = w_redirect;

endmodule
`default_nettype wire

// File: doc/if_id_stage.md
IF_ID_STAGE -- requirements
Module: if_id_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the PC value loaded at reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0000, is the instruction word injected into ID on flush and reset.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 stall  input  1  load-use hold request from the hazard unit.
REQ-006 if_equal  input  1  ID-stage register-operand equality result (rs == rt).
REQ-007 id_beq  input  1  ID instruction is beq.
REQ-008 id_bne  input  1  ID instruction is bne.
REQ-009 id_jump  input  1  ID instruction is j.
REQ-010 id_imm  input  32  sign-extended 16-bit immediate of the ID instruction.
REQ-011 if_instr  input  32  instruction word returned by instruction memory for pc_out (same-cycle, combinational read).
REQ-012 pc_out  output  32  current fetch address to instruction memory.
REQ-013 id_instr  output  32  registered instruction presented to ID.
REQ-014 id_pc_plus4  output  32  registered PC+4 of id_instr.
REQ-015 id_valid  output  1  id_instr is a real instruction (0 = bubble).
REQ-016 redirect  output  1  combinational; branch taken or jump in ID this cycle.

Function
REQ-017 taken SHALL equal id_valid & ((id_beq & if_equal) | (id_bne & ~if_equal)).
REQ-018 redirect SHALL equal ~stall & (taken | (id_valid & id_jump)).
REQ-019 Branch target SHALL be id_pc_plus4 + (id_imm << 2), 32-bit, wrapping modulo 2^32.
REQ-020 Jump target SHALL be {id_pc_plus4[31:28], id_instr[25:0], 2'b00}.
REQ-021 Update priority per edge SHALL be stall > jump > branch > sequential.
REQ-022 stall=1: PC, id_instr, id_pc_plus4 and id_valid SHALL hold; no redirect regardless of if_equal.
REQ-023 Redirect: PC SHALL load the jump target (if id_jump), else the branch target; id_instr SHALL load NOP_INSTR, id_pc_plus4 SHALL load 0, id_valid SHALL load 0 (flush).
REQ-024 Sequential: PC SHALL load PC+4 (wrapping at 32'hFFFF_FFFC to 0); id_instr SHALL load if_instr; id_pc_plus4 SHALL load PC+4; id_valid SHALL load 1.
REQ-025 Fetch-to-ID latency SHALL be one cycle; taken-branch and jump penalty SHALL be exactly one bubble.
REQ-026 id_beq/id_bne/id_jump SHALL be ignored while id_valid=0; simultaneous id_jump and branch SHALL resolve as jump.
REQ-027 pc_out SHALL equal the PC register directly (no combinational path from inputs).

Reset
REQ-028 On reset assertion, regardless of clk: PC=RESET_PC, id_instr=NOP_INSTR, id_pc_plus4=0, id_valid=0; redirect consequently 0.
REQ-029 Reset mid-stall or mid-redirect SHALL discard the pending update; first edge after release fetches RESET_PC normally.

Structure
REQ-030 Shared package SHALL hold WORD_W=32, NOP_INSTR value, RESET_PC default, and opcode constants for beq/bne/j.
REQ-031 The IF/ID pipeline register (hold/flush/load, with valid bit) SHALL be a sub-module named if_id_reg; PC register and next-PC selection stay in if_id_stage.

Verification
REQ-032 Reset then 3 edges with if_instr=32'h2008_0001, no stall -> pc_out 0,4,8,12; id_pc_plus4 4,8,12; id_valid 1 from edge 1.
REQ-033 beq in ID at id_pc_plus4=32'h10, id_imm=3, if_equal=1 -> redirect=1; next edge pc_out=32'h1C, id_instr=NOP, id_valid=0.
REQ-034 bne with if_equal=1 at id_pc_plus4=32'h10 -> redirect=0; pc_out continues sequentially, id_valid=1.
REQ-035 stall=1 for 2 cycles with beq, if_equal=1 in ID -> redirect=0, all outputs frozen; stall drops -> redirect next edge.
REQ-036 j with id_instr[25:0]=26'h40, id_pc_plus4=32'h8000_0010 -> pc_out=32'h8000_0100 next edge; beq id_imm=-4 at id_pc_plus4=32'h8 -> pc_out=32'hFFFF_FFF8 (wrap).
REQ-037 Assert reset asynchronously between edges during a redirect -> outputs take reset values immediately; first post-release fetch at RESET_PC.
